// File: rtl/spec_mem.sv
// spec_mem: buffers diverted AW requests and replays them
// one per spec_release handshake from process_mem.
module spec_mem #(
  parameter int PID_WIDTH  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int SPEC_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            div_awvalid,
  output logic                            div_awready,
  input  logic [PID_WIDTH-1:0]            div_awid,
  input  logic [ADDR_WIDTH-1:0]           div_awaddr,
  input  logic [LEN_WIDTH-1:0]            div_awlen,
  input  logic                            spec_release,
  output logic                            release_ready,
  output logic                            m_awvalid,
  input  logic                            m_awready,
  output logic [PID_WIDTH-1:0]            m_awid,
  output logic [ADDR_WIDTH-1:0]           m_awaddr,
  output logic [LEN_WIDTH-1:0]            m_awlen,
  output logic [$clog2(SPEC_DEPTH):0]     count,
  output logic                            spec_full,
  output logic                            spec_empty,
  output logic                            release_err
);

  localparam int PW = $clog2(SPEC_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [PID_WIDTH-1:0]  id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
  } ent_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  ent_t          mem [SPEC_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  state_t        state;
  state_t        state_nxt;
  logic          push;
  logic          pop;
  ent_t          head;

  assign spec_full   = (count == CW'(SPEC_DEPTH));
  assign spec_empty  = (count == '0);
  assign div_awready = ~spec_full;
  assign push        = div_awvalid & div_awready;
  assign pop         = m_awvalid & m_awready;

  assign head     = mem[rd_ptr];
  assign m_awid   = head.id;
  assign m_awaddr = head.addr;
  assign m_awlen  = head.len;

  // Entry storage needs no reset; contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{id: div_awid, addr: div_awaddr, len: div_awlen};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      release_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && spec_release && spec_empty) begin
        release_err <= 1'b1;
      end
    end
  end

  // An empty-buffer release skips ISSUE so process_mem still gets an ack.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (spec_release) state_nxt = spec_empty ? ACK : ISSUE;
      end
      ISSUE: begin
        if (m_awready) state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_awvalid     = 1'b0;
    release_ready = 1'b0;
    unique case (state)
      ISSUE:   m_awvalid     = 1'b1;
      ACK:     release_ready = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spec_mem.sv
// tb_spec_mem: directed stimulus with a scoreboard queue of
// expected replays, checked by an independent monitor.
module tb_spec_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_awvalid = 1'b0;
  logic        div_awready;
  logic [3:0]  div_awid = '0;
  logic [31:0] div_awaddr = '0;
  logic [7:0]  div_awlen = '0;
  logic        spec_release = 1'b0;
  logic        release_ready;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [3:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  count;
  logic        spec_full;
  logic        spec_empty;
  logic        release_err;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } exp_t;

  exp_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;

  spec_mem dut (
    .clk(clk), .rst(rst),
    .div_awvalid(div_awvalid), .div_awready(div_awready),
    .div_awid(div_awid), .div_awaddr(div_awaddr),
    .div_awlen(div_awlen),
    .spec_release(spec_release), .release_ready(release_ready),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .count(count), .spec_full(spec_full), .spec_empty(spec_empty),
    .release_err(release_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: one negedge with valid&ready == one pop at next posedge.
  always @(negedge clk) begin
    if (!rst && m_awvalid && m_awready) begin
      n_vec++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL replay: unexpected id %0h, queue empty", m_awid);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if (m_awid !== e.id || m_awaddr !== e.addr
            || m_awlen !== e.len) begin
          n_err++;
          $display("FAIL replay: got %0h/%0h/%0h expected %0h/%0h/%0h",
                   m_awid, m_awaddr, m_awlen, e.id, e.addr, e.len);
        end
      end
    end
  end

  task automatic push(input logic [3:0] id, input logic [31:0] addr,
                      input logic [7:0] len, input bit accept);
    @(posedge clk); #1;
    div_awvalid = 1'b1;
    div_awid    = id;
    div_awaddr  = addr;
    div_awlen   = len;
    if (accept) expq.push_back('{id: id, addr: addr, len: len});
    @(posedge clk); #1;
    div_awvalid = 1'b0;
  endtask

  task automatic release_req(output int cyc);
    cyc = 0;
    @(posedge clk); #1;
    spec_release = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (release_ready) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL release_timeout: no release_ready in 30 cycles");
    end
    @(posedge clk); #1;
    spec_release = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", release_ready, 0);
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_awvalid) begin
        seen = 1;
        break;
      end
    end
    chk("issue_seen", seen, 1);
  endtask

  int cyc;

  initial begin
    #12;
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_relrdy", release_ready, 0);
    chk("rst_err", release_err, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", spec_empty, 1);
    chk("rst_full", spec_full, 0);
    chk("rst_awready", div_awready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    push(4'd1, 32'h100, 8'd0, 1);
    push(4'd2, 32'h200, 8'd3, 1);
    push(4'd3, 32'h300, 8'd7, 1);
    @(negedge clk);
    chk("fill3_count", count, 3);
    chk("fill3_empty", spec_empty, 0);
    chk("fill3_awready", div_awready, 1);
    chk("fill3_awvalid", m_awvalid, 0);

    m_awready = 1'b1;
    release_req(cyc);
    chk("rel_latency", cyc, 3);
    chk("rel1_count", count, 2);

    push(4'd4, 32'h400, 8'd1, 1);
    push(4'd6, 32'h600, 8'd2, 1);
    @(negedge clk);
    chk("full_flag", spec_full, 1);
    chk("full_awready", div_awready, 0);
    push(4'd5, 32'h500, 8'd5, 0);
    @(negedge clk);
    chk("full_reject_count", count, 4);
    release_req(cyc);
    chk("after_full_rel", count, 3);
    push(4'd5, 32'h500, 8'd5, 1);
    @(negedge clk);
    chk("push5_count", count, 4);
    release_req(cyc);
    release_req(cyc);
    chk("pre_stall_count", count, 2);

    m_awready = 1'b0;
    @(posedge clk); #1;
    spec_release = 1'b1;
    wait_valid();
    div_awvalid = 1'b1;
    div_awid    = 4'd8;
    div_awaddr  = 32'h800;
    div_awlen   = 8'd4;
    expq.push_back('{id: 4'd8, addr: 32'h800, len: 8'd4});
    @(posedge clk); #1;
    div_awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", m_awvalid, 1);
      chk("stall_id", m_awid, 4'd6);
      chk("stall_addr", m_awaddr, 32'h600);
    end
    chk("stall_count", count, 3);
    @(posedge clk); #1;
    m_awready = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (release_ready) begin
        cyc = i;
        break;
      end
    end
    chk("stall_ack_lat", cyc, 2);
    @(posedge clk); #1;
    spec_release = 1'b0;
    @(negedge clk);
    chk("stall_pop_count", count, 2);

    release_req(cyc);
    release_req(cyc);
    chk("drain_empty", spec_empty, 1);

    release_req(cyc);
    chk("empty_rel_lat", cyc, 2);
    chk("empty_rel_err", release_err, 1);
    chk("empty_rel_count", count, 0);

    for (int i = 0; i < 10; i++) begin
      push(4'(i), 32'(i * 16), 8'(i), 1);
      release_req(cyc);
    end
    chk("wrap_count", count, 0);
    chk("err_sticky", release_err, 1);
    chk("wrap_drained", expq.size(), 0);

    push(4'hA, 32'hA00, 8'd9, 1);
    m_awready = 1'b0;
    @(posedge clk); #1;
    spec_release = 1'b1;
    wait_valid();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", m_awvalid, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_err", release_err, 0);
    expq.delete();
    spec_release = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_awready = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", m_awvalid, 0);
    chk("post_rst_ack", release_ready, 0);
    chk("post_rst_empty", spec_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
